// File: rtl/pixel_descrambler.sv
// Receive-side camera-link descrambler: owns the per-frame key handshake and
// XORs the matching 12-bit LFSR key stream out of the incoming RGB444 pixels.

module pixel_descrambler_lane #(
  parameter int VEC_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [VEC_W-1:0] din,
  input  logic [VEC_W-1:0] key,
  output logic [VEC_W-1:0] dout
);
  // Dropped pixels are forced to zero so the display never sees scrambled data.
  always_ff @(posedge clk or posedge reset)
    if (reset) dout <= '0;
    else       dout <= en ? (din ^ key) : '0;
endmodule

module pixel_descrambler #(
  parameter logic [11:0] SEED_INIT = 12'hACE,
  parameter logic [11:0] SEED_STEP = 12'h3A7,
  parameter int          PULSE_LEN = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [11:0] pix_in,
  input  logic        href_in,
  input  logic        vsync_in,
  output logic [11:0] pix_out,
  output logic        de_out,
  output logic        href_out,
  output logic        vsync_out,
  output logic        key_reset_c,
  output logic [11:0] key_code,
  output logic [7:0]  frame_cnt,
  output logic        sync_err
);
  localparam int NUM_LANES = 3;
  localparam int VEC_W     = 4;
  localparam int STAGES    = 1;
  localparam int CW        = $clog2(PULSE_LEN);

  typedef enum logic [1:0] {IDLE, SYNC, ARMED, RUN} state_t;

  state_t          state, state_nxt;
  logic [11:0]     lfsr, lfsr_step, seed_sum, seed_next;
  logic [CW-1:0]   pulse_cnt;
  logic            first_frame, vs_rise, active, pulse_done, sync_enter;
  logic [STAGES:0] vld_pipe;

  logic [NUM_LANES-1:0][VEC_W-1:0] pix_lanes, key_lanes, out_lanes;

  assign vs_rise    = vsync_in & ~vsync_out;
  assign active     = (state == ARMED) || (state == RUN);
  assign pulse_done = (pulse_cnt == CW'(PULSE_LEN - 1));
  assign lfsr_step  = {lfsr[11] ^ lfsr[5] ^ lfsr[3] ^ lfsr[0], lfsr[11:1]};
  assign seed_sum   = key_code + SEED_STEP;
  // A zero seed would lock the LFSR, so it falls back to the initial seed.
  assign seed_next  = (first_frame || seed_sum == 12'h000) ? SEED_INIT : seed_sum;
  assign vld_pipe[0] = href_in & active;

  always_comb begin
    state_nxt  = state;
    sync_enter = 1'b0;
    case (state)
      IDLE:  if (vs_rise) begin state_nxt = SYNC; sync_enter = 1'b1; end
      SYNC:  if (pulse_done) state_nxt = ARMED;
      ARMED: if (vs_rise) begin state_nxt = SYNC; sync_enter = 1'b1; end
             else if (href_in) state_nxt = RUN;
      RUN:   if (vs_rise) begin state_nxt = SYNC; sync_enter = 1'b1; end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else       state <= state_nxt;

  // Key handshake: seed load, frame count and the fixed-length reload pulse.
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      key_code    <= SEED_INIT;
      first_frame <= 1'b1;
      frame_cnt   <= 8'h00;
      key_reset_c <= 1'b0;
      pulse_cnt   <= '0;
    end else if (sync_enter) begin
      key_code    <= seed_next;
      first_frame <= 1'b0;
      frame_cnt   <= frame_cnt + 8'd1;
      key_reset_c <= 1'b1;
      pulse_cnt   <= '0;
    end else if (state == SYNC) begin
      if (pulse_done) key_reset_c <= 1'b0;
      else            pulse_cnt   <= pulse_cnt + CW'(1);
    end

  // Seed load wins over stepping; the stream only advances on accepted pixels.
  always_ff @(posedge clk or posedge reset)
    if (reset)            lfsr <= SEED_INIT;
    else if (sync_enter)  lfsr <= seed_next;
    else if (vld_pipe[0]) lfsr <= lfsr_step;

  always_ff @(posedge clk or posedge reset)
    if (reset)                          sync_err <= 1'b0;
    else if (state == SYNC && href_in)  sync_err <= 1'b1;

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      href_out            <= 1'b0;
      vsync_out           <= 1'b0;
      vld_pipe[STAGES:1]  <= '0;
    end else begin
      href_out            <= href_in;
      vsync_out           <= vsync_in;
      vld_pipe[STAGES:1]  <= vld_pipe[STAGES-1:0];
    end

  assign de_out = vld_pipe[STAGES];

  assign pix_lanes = pix_in;
  assign key_lanes = lfsr;

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    pixel_descrambler_lane #(.VEC_W(VEC_W)) u_lane (
      .clk   (clk),
      .reset (reset),
      .en    (vld_pipe[0]),
      .din   (pix_lanes[g]),
      .key   (key_lanes[g]),
      .dout  (out_lanes[g])
    );
  end

  assign pix_out = out_lanes;
endmodule

// File: doc/pixel_descrambler.md
# pixel_descrambler

Receive-side counterpart of the camera-link pixel scrambler. The block owns the per-frame key handshake: at each frame start it issues a new 12-bit seed and a key-reset pulse toward the scrambler. It then runs the matching 12-bit LFSR locally and XORs it out of the incoming RGB444 stream, delivering plain pixels with aligned href/vsync/DE to the display path.

## Interface
- SEED_INIT, 12'hACE, seed for the first frame after reset; also replaces any computed seed of zero
- SEED_STEP, 12'h3A7, per-frame seed increment (mod 4096)
- PULSE_LEN, 4, cycles key_reset_c is held high (≥3, so the scrambler's 2-flop edge detect sees it)
- clk  in  1  pixel clock; all logic on rising edge
- reset  in  1  asynchronous, active-high
- pix_in  in  12  scrambled pixel {R[3:0],G[3:0],B[3:0]}
- href_in  in  1  line valid; one pixel per cycle while high
- vsync_in  in  1  frame sync, active-high
- pix_out  out  12  descrambled pixel, 0 when de_out=0
- de_out  out  1  pixel valid, aligned with pix_out
- href_out  out  1  href_in delayed 1 cycle
- vsync_out  out  1  vsync_in delayed 1 cycle
- key_reset_c  out  1  key-reload pulse to scrambler
- key_code  out  12  seed to scrambler, stable from SYNC entry until next SYNC entry
- frame_cnt  out  8  frames synced, wraps 255→0
- sync_err  out  1  sticky: href_in seen during SYNC

## Operation
- LFSR: feedback = l[11]^l[5]^l[3]^l[0]; step l ← {feedback, l[11:1]}. Identical polynomial and direction to the scrambler.
- FSM states: IDLE, SYNC, ARMED, RUN.
  - IDLE: wait for vsync_in rising edge (vsync_in=1 and previous sample 0).
  - SYNC entry, on the cycle after the rising edge:
    - key_code ← seed_next.
    - lfsr ← seed_next.
    - frame_cnt += 1.
    - key_reset_c=1 for exactly PULSE_LEN cycles, then → ARMED.
  - ARMED: key_reset_c=0. On first cycle with href_in=1 → RUN; that pixel is descrambled.
  - RUN: each cycle with href_in=1: pix_out ← pix_in ^ lfsr, then lfsr steps. When href_in=0, lfsr holds.
  - vsync_in rising edge in ARMED or RUN → SYNC, starting a new frame.
- Seed sequence: the first SYNC after reset uses SEED_INIT. Each later SYNC uses (previous key_code + SEED_STEP) mod 4096. A result of 12'h000 is replaced by SEED_INIT.
- Vsync rising edge during SYNC is ignored: the pulse completes and no new seed is issued.
- href_in=1 during SYNC or IDLE:
  - pixel is dropped (de_out=0, pix_out=0), lfsr does not step.
  - In SYNC only, sync_err ← 1. sync_err is cleared only by reset.
- Reset mid-frame returns to IDLE immediately. The next frame re-syncs with SEED_INIT.

## Timing
- Reset values:
  - pix_out=0, de_out=0, href_out=0, vsync_out=0
  - key_reset_c=0, key_code=SEED_INIT
  - frame_cnt=0, sync_err=0
  - lfsr=SEED_INIT, state IDLE
- Pixel latency is 1 cycle. pix_out, de_out, href_out and vsync_out are all registered from the same input cycle.
- de_out = registered (href_in & state∈{ARMED,RUN}).
- key_reset_c rises 1 cycle after the vsync_in rising edge is sampled and is high for PULSE_LEN cycles. key_code is valid in the same cycle key_reset_c rises.
- Key-stream alignment: the Nth href-valid pixel of a frame (N from 0) uses the seed stepped N times. The scrambler must apply the same stepping rule.
- frame_cnt wraps 8'hFF→8'h00 without a flag.

## Test plan
- Reset check: assert reset mid-stream -> every output at its reset value immediately; state IDLE; next vsync rising issues key_code=0xACE.
- First frame: vsync 0→1 -> key_reset_c high cycles 1–4 after edge, key_code=0xACE, frame_cnt=1. Then href=1 with pix_in=0xACE,0x567 -> next cycles pix_out=0x000,0x000 with de_out=1.
- Seed sequence: second vsync rising edge -> key_code=0xE75, frame_cnt=2. With SEED_INIT=0xC59, second frame seed computes to 0x000 -> key_code=0xC59.
- href gaps: href pattern 1,0,0,1 with pix_in=0x000 -> pix_out=0xACE, 0, 0, 0x567; de_out=1,0,0,1.
- Protocol errors: href_in=1 during SYNC -> sync_err=1 and de_out stays 0. Second vsync edge during SYNC -> pulse still exactly 4 cycles, frame_cnt increments once.
- Wrap: run 256 frames -> frame_cnt 0xFF→0x00.
